// File: rtl/key_debounce_sync.sv
// key_debounce_sync: conditions the raw active-low DE0-Nano push-buttons.
// Each key gets a two-flop synchronizer, a stability counter and a
// four-state debounce FSM. The FSM produces a clean level, one-cycle
// press/release pulses and a toggle latch that flips on every press.
// Keys are fully independent; nothing is shared between generate lanes.

module key_debounce_sync #(
   parameter int EXT_CLOCK_FREQ  = 50000000,
   parameter int KEY_SIZE        = 2,
   parameter int DEBOUNCE_CYCLES = EXT_CLOCK_FREQ / 100
) (
   input  logic                EXTCLK,
   input  logic                RST,
   input  logic [KEY_SIZE-1:0] KEY,
   output logic [KEY_SIZE-1:0] key_level,
   output logic [KEY_SIZE-1:0] key_press,
   output logic [KEY_SIZE-1:0] key_release,
   output logic [KEY_SIZE-1:0] key_toggle
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so this width never wraps.
   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE_UP    = 2'd0,
      CHECK_DOWN = 2'd1,
      HELD_DOWN  = 2'd2,
      CHECK_UP   = 2'd3
   } state_t;

   for (genvar i = 0; i < KEY_SIZE; i++) begin : g_key

      logic                 sync_meta;
      logic                 sync_stable;
      logic                 sync_pressed;
      state_t               state;
      logic [CNT_WIDTH-1:0] cnt;
      logic                 level_q;
      logic                 press_q;
      logic                 release_q;
      logic                 toggle_q;

      // Two-flop synchronizer; resets to 1 so the key reads as released.
      always_ff @(posedge EXTCLK or posedge RST) begin
         if (RST) begin
            sync_meta   <= 1'b1;
            sync_stable <= 1'b1;
         end else begin
            sync_meta   <= KEY[i];
            sync_stable <= sync_meta;
         end
      end

      assign sync_pressed = ~sync_stable;

      // Debounce FSM: a change must hold DEBOUNCE_CYCLES edges in a CHECK state before it commits.
      always_ff @(posedge EXTCLK or posedge RST) begin
         if (RST) begin
            state     <= IDLE_UP;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
               IDLE_UP: begin
                  if (sync_pressed) begin
                     state <= CHECK_DOWN;
                     cnt   <= '0;
                  end
               end
               CHECK_DOWN: begin
                  if (!sync_pressed) begin
                     state <= IDLE_UP;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state    <= HELD_DOWN;
                     cnt      <= '0;
                     level_q  <= 1'b1;
                     press_q  <= 1'b1;
                     toggle_q <= ~toggle_q;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               HELD_DOWN: begin
                  if (!sync_pressed) begin
                     state <= CHECK_UP;
                     cnt   <= '0;
                  end
               end
               CHECK_UP: begin
                  if (sync_pressed) begin
                     state <= HELD_DOWN;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state     <= IDLE_UP;
                     cnt       <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= IDLE_UP;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_toggle[i]  = toggle_q;

   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: directed stimulus for key_debounce_sync with a
// scoreboard. Stimulus pushes the expected press/release events; a monitor
// pops one whenever the DUT pulses key_press or key_release.

module tb_key_debounce_sync;

   localparam int KEY_SIZE        = 2;
   localparam int DEBOUNCE_CYCLES = 8;
   // One edge to capture the raw level, two synchronizer edges, then the
   // FSM commits DEBOUNCE_CYCLES edges after entering its CHECK state.
   localparam int LATENCY         = DEBOUNCE_CYCLES + 3;

   typedef struct {
      int cyc;
      int key;
      bit is_press;
      bit level;
      bit toggle;
   } exp_event_t;

   logic                EXTCLK = 1'b0;
   logic                RST;
   logic [KEY_SIZE-1:0] KEY;
   logic [KEY_SIZE-1:0] key_level;
   logic [KEY_SIZE-1:0] key_press;
   logic [KEY_SIZE-1:0] key_release;
   logic [KEY_SIZE-1:0] key_toggle;

   int                  cyc = 0;
   int                  tests_run = 0;
   int                  tests_failed = 0;
   exp_event_t          exp_q[$];
   logic [KEY_SIZE-1:0] exp_toggle = '0;
   exp_event_t          mon_ev;

   key_debounce_sync #(
      .EXT_CLOCK_FREQ (50000000),
      .KEY_SIZE       (KEY_SIZE),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .EXTCLK     (EXTCLK),
      .RST        (RST),
      .KEY        (KEY),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_toggle (key_toggle)
   );

   // Free-running 100 MHz bench clock.
   always #5 EXTCLK = ~EXTCLK;

   // Edge counter used to timestamp expected and observed events.
   always @(posedge EXTCLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, actual, expected);
      end
   endtask

   // Drive one key; when the change is expected to be accepted, queue its event.
   task automatic applyStimulus(input int k, input bit pressed, input bit accepted);
      exp_event_t ev;
      KEY[k] = ~pressed;
      if (accepted) begin
         if (pressed) exp_toggle[k] = ~exp_toggle[k];
         ev.cyc      = cyc + LATENCY;
         ev.key      = k;
         ev.is_press = pressed;
         ev.level    = pressed;
         ev.toggle   = exp_toggle[k];
         exp_q.push_back(ev);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge EXTCLK);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_level"},   int'(key_level),   0);
      checkOutput({tag, "_press"},   int'(key_press),   0);
      checkOutput({tag, "_release"}, int'(key_release), 0);
      checkOutput({tag, "_toggle"},  int'(key_toggle),  0);
   endtask

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge EXTCLK) begin
      for (int i = 0; i < KEY_SIZE; i++) begin
         if (key_press[i] || key_release[i]) begin
            checkOutput("press_release_exclusive", int'(key_press[i] & key_release[i]), 0);
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_pulse key %0d at cycle %0d: got press=%0b release=%0b, required no pulse",
                        i, cyc, key_press[i], key_release[i]);
            end else begin
               mon_ev = exp_q.pop_front();
               checkOutput("event_cycle",  cyc,                mon_ev.cyc);
               checkOutput("event_key",    i,                  mon_ev.key);
               checkOutput("event_kind",   int'(key_press[i]), int'(mon_ev.is_press));
               checkOutput("event_level",  int'(key_level[i]), int'(mon_ev.level));
               checkOutput("event_toggle", int'(key_toggle[i]), int'(mon_ev.toggle));
            end
         end
      end
   end

   initial begin
      RST = 1'b0;
      KEY = 2'b10;
      #1 RST = 1'b1;

      // Test 1: key 0 held through reset, accepted as a fresh press afterwards.
      waitCycles(4);
      checkAllZero("reset");
      RST = 1'b0;
      exp_toggle = '0;
      applyStimulus(0, 1'b1, 1'b1);
      waitCycles(LATENCY - 1);
      checkOutput("reset_level_before_commit", int'(key_level[0]), 0);
      waitCycles(9);
      checkOutput("reset_level_after_commit", int'(key_level[0]), 1);
      applyStimulus(0, 1'b0, 1'b1);
      waitCycles(20);

      // Test 2: clean press and release on key 1.
      applyStimulus(1, 1'b1, 1'b1);
      waitCycles(20);
      checkOutput("clean_level_held", int'(key_level[1]), 1);
      checkOutput("clean_toggle",     int'(key_toggle[1]), 1);
      applyStimulus(1, 1'b0, 1'b1);
      waitCycles(20);
      checkOutput("clean_level_released", int'(key_level[1]), 0);

      // Test 3: bounce every 3 cycles, then a stable press.
      for (int j = 0; j < 10; j++) begin
         applyStimulus(0, (j % 2) == 0, 1'b0);
         waitCycles(3);
      end
      applyStimulus(0, 1'b1, 1'b1);
      waitCycles(20);
      checkOutput("bounce_level", int'(key_level[0]), 1);
      applyStimulus(0, 1'b0, 1'b1);
      waitCycles(20);

      // Test 4: a 7-cycle glitch is rejected, a 9-cycle pulse is accepted.
      applyStimulus(0, 1'b1, 1'b0);
      waitCycles(7);
      applyStimulus(0, 1'b0, 1'b0);
      waitCycles(20);
      checkOutput("glitch_level",  int'(key_level[0]), 0);
      checkOutput("glitch_toggle", int'(key_toggle[0]), 0);
      applyStimulus(0, 1'b1, 1'b1);
      waitCycles(9);
      applyStimulus(0, 1'b0, 1'b1);
      waitCycles(20);
      checkOutput("pulse9_toggle", int'(key_toggle[0]), 1);

      // Test 5: reset clears toggles, then three presses on key 1.
      RST = 1'b1;
      exp_toggle = '0;
      waitCycles(3);
      checkAllZero("reset2");
      RST = 1'b0;
      waitCycles(5);
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1, 1'b1, 1'b1);
         waitCycles(15);
         checkOutput("toggle_seq", int'(key_toggle[1]), (j % 2) == 0 ? 1 : 0);
         applyStimulus(1, 1'b0, 1'b1);
         waitCycles(15);
      end
      checkOutput("toggle_key0_level",  int'(key_level[0]), 0);
      checkOutput("toggle_key0_toggle", int'(key_toggle[0]), 0);

      // Test 6: reset lands while key 0 is mid-check; press accepted after release.
      applyStimulus(0, 1'b1, 1'b0);
      waitCycles(8);
      RST = 1'b1;
      exp_toggle = '0;
      waitCycles(1);
      checkOutput("midcheck_level", int'(key_level[0]), 0);
      waitCycles(2);
      RST = 1'b0;
      applyStimulus(0, 1'b1, 1'b1);
      waitCycles(5);
      checkOutput("midcheck_level_after_rst", int'(key_level[0]), 0);
      waitCycles(15);
      checkOutput("midcheck_level_accepted", int'(key_level[0]), 1);
      applyStimulus(0, 1'b0, 1'b1);
      waitCycles(20);

      // Drain: every queued event must have been observed.
      waitCycles(30);
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("final_level", int'(key_level), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
